// File: rtl/arith_pkg.sv
// Shared types for the arithmetic datapath blocks.
package arith_pkg;

    // Divider control states: idle, iterating one quotient bit per cycle,
    // and a single publish cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/sub_borrow_n.sv
// Combinational a - b producing a WIDTH-bit difference and a borrow flag.
// Built as a + ~b + 1 so it maps onto the same adder as the add/sub unit;
// the borrow is the inverted carry-out.
module sub_borrow_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] sum;

    // Complement-and-add with carry-in 1; the carry-out lands in sum[WIDTH].
    always_comb begin
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    end

    assign diff   = sum[WIDTH-1:0];
    assign borrow = ~sum[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// One quotient bit is resolved per RUN cycle, MSB first. The dividend
// register doubles as the quotient register: each step shifts a dividend
// bit out of the top and the new quotient bit in at the bottom.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr_q, dsr_d;        // latched divisor
    logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
    logic             dbz_pend_q, dbz_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    // The partial remainder is always below 2^(WIDTH-1) before its last shift,
    // so dropping its MSB when forming the trial value loses nothing.
    assign trial = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

    sub_borrow_n #(.WIDTH(WIDTH)) u_sub (
        .a      (trial),
        .b      (dsr_q),
        .diff   (diff),
        .borrow (borrow)
    );

    // Next-state and datapath update for the IDLE/RUN/FIN sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        rem_d      = rem_q;
        dbz_pend_d = dbz_pend_q;
        quo_d      = quo_q;
        rmd_d      = rmd_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvd_d      = dividend;
                        dsr_d      = divisor;
                        rem_d      = '0;
                        cnt_d      = CW'(WIDTH - 1);
                        dbz_pend_d = 1'b0;
                        state_d    = RUN;
                    end else begin
                        // Divide by zero skips the iteration entirely.
                        dvd_d      = '1;
                        rem_d      = dividend;
                        dbz_pend_d = 1'b1;
                        state_d    = FIN;
                    end
                end
            end
            RUN: begin
                // Keep the difference on no borrow, otherwise restore the trial.
                rem_d = borrow ? trial : diff;
                dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
                if (cnt_q == '0) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIN: begin
                quo_d   = dvd_q;
                rmd_d   = rem_q;
                dbz_d   = dbz_pend_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    // State and output registers; reset abandons any divide without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            dbz_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quo_q      <= '0;
            rmd_q      <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            rem_q      <= rem_d;
            dbz_pend_q <= dbz_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            quo_q      <= quo_d;
            rmd_q      <= rmd_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench: directed cases on a 4-bit divider, random sweep on an
// 8-bit divider, both checked against plain integer division.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       busy4, done4, dbz4, busy8, done8, dbz8;
    logic [3:0] q4, r4;
    logic [7:0] q8, r8;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .dividend(a4), .divisor(b4),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4),
        .div_by_zero(dbz4)
    );

    seq_divider #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
        .div_by_zero(dbz8)
    );

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
    } exp_t;

    exp_t exp4[$];
    exp_t exp8[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_done4 = 1'b0;
    logic prev_done8 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division; divide by zero gives all-ones / dividend.
    function automatic exp_t model(input int a, input int b, input int w);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = (1 << w) - 1;
            e.r = a;
            e.dbz = 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 0;
        end
        return e;
    endfunction

    // Monitor: every done pops the scoreboard and checks result and framing.
    task automatic mon_step();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            prev_done4 = 1'b0;
            prev_done8 = 1'b0;
        end else begin
            if (done4) begin
                chk("busy_with_done4", busy4, 0);
                chk("done4_width", prev_done4, 0);
                chk("done4_expected", exp4.size() != 0, 1);
                if (exp4.size() != 0) begin
                    e = exp4.pop_front();
                    chk("q4", q4, e.q);
                    chk("r4", r4, e.r);
                    chk("dbz4", dbz4, e.dbz);
                end
            end
            if (done8) begin
                chk("busy_with_done8", busy8, 0);
                chk("done8_width", prev_done8, 0);
                chk("done8_expected", exp8.size() != 0, 1);
                if (exp8.size() != 0) begin
                    e = exp8.pop_front();
                    chk("q8", q8, e.q);
                    chk("r8", r8, e.r);
                    chk("dbz8", dbz8, e.dbz);
                    if (e.b != 0) begin
                        chk("inv8", int'(q8) * e.b + int'(r8), e.a);
                        chk("rem_lt_div8", int'(r8) < e.b, 1);
                    end
                end
            end
            prev_done4 = done4;
            prev_done8 = done8;
        end
    endtask

    // Issue one 4-bit divide and wait for done; lat/busy checks skipped when < 0.
    task automatic op4(input int a, input int b, input int exp_lat, input int exp_busy);
        int cyc = 0;
        int bcnt = 0;
        logic seen = 1'b0;
        @(negedge clk);
        start4 = 1'b1;
        a4 = 4'(a);
        b4 = 4'(b);
        exp4.push_back(model(a, b, 4));
        while (!seen && cyc < 40) begin
            @(negedge clk);
            start4 = 1'b0;
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            cyc++;
            if (busy4) bcnt++;
            if (done4) seen = 1'b1;
        end
        chk("done4_seen", seen, 1);
        if (exp_lat >= 0) chk("lat4", cyc - 1, exp_lat);
        if (exp_busy >= 0) chk("busy4_cycles", bcnt, exp_busy);
    endtask

    task automatic op8(input int a, input int b);
        int cyc = 0;
        logic seen = 1'b0;
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'(a);
        b8 = 8'(b);
        exp8.push_back(model(a, b, 8));
        while (!seen && cyc < 40) begin
            @(negedge clk);
            start8 = 1'b0;
            cyc++;
            if (done8) seen = 1'b1;
        end
        chk("done8_seen", seen, 1);
        chk("lat8", cyc - 1, (b == 0) ? 1 : 9);
    endtask

    initial begin
        int   a, b, sel, cyc;
        logic seen;
        rst = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_q4", q4, 0);
        chk("rst_r4", r4, 0);
        chk("rst_dbz4", dbz4, 0);
        chk("rst_busy8", busy8, 0);
        rst = 1'b0;

        fork
            forever mon_step();
        join_none

        // Basic divides and divide by zero, with latency and busy length.
        op4(13, 3, 5, 4);
        op4(7, 0, 1, 0);
        op4(15, 1, 5, 4);
        op4(2, 5, 5, 4);
        op4(0, 9, 5, 4);
        op4(9, 15, -1, -1);

        // A start during RUN is dropped; the next one after done is taken.
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
        exp4.push_back(model(12, 5, 4));
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1;
        @(negedge clk);
        @(negedge clk);
        start4 = 1'b0;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done4) seen = 1'b1;
        end
        chk("done4_seen_drop", seen, 1);
        op4(1, 1, 5, 4);

        // Reset in the middle of RUN: outputs clear and no done appears.
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd13; b4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy4", busy4, 0);
        chk("midrst_done4", done4, 0);
        chk("midrst_q4", q4, 0);
        chk("midrst_r4", r4, 0);
        chk("midrst_dbz4", dbz4, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        op4(9, 2, 5, 4);

        // Random 8-bit sweep, biased toward zero and small divisors.
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 255));
            sel = int'($urandom_range(0, 9));
            if (sel == 0) b = 0;
            else if (sel < 4) b = int'($urandom_range(1, 15));
            else b = int'($urandom_range(1, 255));
            op8(a, b);
        end

        repeat (4) @(negedge clk);
        chk("exp4_drained", exp4.size(), 0);
        chk("exp8_drained", exp8.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
